// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI-controlled PWM expander: register map, CTRL bit
// positions, SPI frame geometry and the frame-tracking state encoding.
package spi_pwm_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BYTE_BITS  = 8;

    localparam logic [6:0] ADDR_CTRL  = 7'h40;
    localparam logic [6:0] ADDR_PRESC = 7'h41;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOAD_BIT = 1;

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } frame_state_t;

endpackage

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave framing: brings the pins into CLK, counts SCLK edges and turns
// each 16-bit chip-select window into one register write strobe or one register read.
module spi_slave_frame
    import spi_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       wr_strobe,
    output logic [6:0] addr,
    output logic [7:0] data,
    output logic [6:0] rd_addr,
    input  logic [7:0] rd_data
);

    logic         cs_meta, cs_s;
    logic         sclk_meta, sclk_s, sclk_d;
    logic         mosi_meta, mosi_s;
    logic         sclk_rise, sclk_fall;
    logic         in_frame, addr_done, data_done;
    logic [4:0]   bit_cnt;
    logic [6:0]   rx_shift;
    logic [7:0]   tx_shift;
    logic         rw, rd_load, data_phase;
    frame_state_t state, state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta   <= 1'b0;
            cs_s      <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            cs_meta   <= cs_n;
            cs_s      <= cs_meta;
            sclk_meta <= sclk;
            sclk_s    <= sclk_meta;
            sclk_d    <= sclk_s;
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign in_frame  = (state == ST_SHIFT) && !cs_s;
    assign addr_done = in_frame && sclk_rise && (bit_cnt == 5'(BYTE_BITS - 1));
    assign data_done = in_frame && sclk_rise && (bit_cnt == 5'(FRAME_BITS - 1));

    // Reset leaves the chip-select synchroniser reading "selected", so a frame
    // in flight across reset is skipped until chip select is seen high again.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RESYNC;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_RESYNC: if (cs_s) state_next = ST_IDLE;
            ST_IDLE:   if (!cs_s) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_s)           state_next = ST_IDLE;
                else if (data_done) state_next = ST_DONE;
            end
            ST_DONE:   if (cs_s) state_next = ST_IDLE;
            default:   state_next = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            addr       <= '0;
            data       <= '0;
            rw         <= 1'b0;
            rd_load    <= 1'b0;
            data_phase <= 1'b0;
            wr_strobe  <= 1'b0;
        end else begin
            wr_strobe <= data_done && rw;
            rd_load   <= addr_done && !rx_shift[6];
            if (!in_frame) begin
                bit_cnt    <= '0;
                tx_shift   <= '0;
                data_phase <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    bit_cnt  <= bit_cnt + 5'd1;
                end
                if (addr_done) begin
                    addr       <= {rx_shift[5:0], mosi_s};
                    rw         <= rx_shift[6];
                    data_phase <= 1'b1;
                end
                if (data_done) data <= {rx_shift[6:0], mosi_s};
                // The MSB stays put across the fall right after rise 8 so the
                // master samples it on rise 9.
                if (rd_load)
                    tx_shift <= rd_data;
                else if (sclk_fall && bit_cnt > 5'(BYTE_BITS))
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign miso    = data_phase & tx_shift[7];
    assign rd_addr = addr;

endmodule

// File: rtl/spi_pwm_expander.sv
// SPI-programmable PWM expander: shadowed duty registers, prescaled period counter
// and one registered PWM output per channel, with duty updates applied at wrap.
module spi_pwm_expander
    import spi_pwm_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              _CS,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [NUM_CH-1:0] PWMOutputs
);

    localparam int                  CNT_LAST_INT = (1 << PWM_BITS) - 2;
    localparam logic [PWM_BITS-1:0] CNT_LAST     = CNT_LAST_INT[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] duty_sh  [NUM_CH];
    logic [PWM_BITS-1:0] duty_act [NUM_CH];
    logic                en, load_pending;
    logic [7:0]          presc, presc_act, presc_cnt;
    logic [PWM_BITS-1:0] cnt;

    logic       wr_strobe;
    logic [6:0] addr, rd_addr;
    logic [7:0] data, rd_data;
    logic       ctrl_wr, load_req, en_rise, tick, advance, wrap, copy;

    spi_slave_frame u_frame (
        .clk       (CLK),
        .rst       (RST),
        .cs_n      (_CS),
        .sclk      (SCLK),
        .mosi      (MOSI),
        .miso      (MISO),
        .wr_strobe (wr_strobe),
        .addr      (addr),
        .data      (data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    assign ctrl_wr  = wr_strobe && (addr == ADDR_CTRL);
    assign load_req = ctrl_wr && data[CTRL_LOAD_BIT];
    assign en_rise  = ctrl_wr && data[CTRL_EN_BIT] && !en;
    assign tick     = (presc_cnt == presc_act);
    assign advance  = tick && !en_rise;
    assign wrap     = advance && (cnt == CNT_LAST);
    // A LOAD request landing on a wrap is deferred to the following wrap.
    assign copy     = wrap && load_pending && !load_req;

    always_comb begin
        rd_data = 8'h00;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (rd_addr == 7'(ch)) rd_data = 8'(duty_sh[ch]);
        if (rd_addr == ADDR_CTRL) begin
            rd_data[CTRL_EN_BIT]   = en;
            rd_data[CTRL_LOAD_BIT] = load_pending;
        end else if (rd_addr == ADDR_PRESC) begin
            rd_data = presc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the duty tables are small flop arrays, not RAM, so they can be
            // and are cleared by reset along with the rest of the state.
            duty_sh      <= '{default: '0};
            duty_act     <= '{default: '0};
            en           <= 1'b0;
            load_pending <= 1'b0;
            presc        <= '0;
            presc_act    <= '0;
            presc_cnt    <= '0;
            cnt          <= '0;
            PWMOutputs   <= '0;
        end else begin
            if (wr_strobe) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    if (addr == 7'(ch)) duty_sh[ch] <= data[PWM_BITS-1:0];
                if (addr == ADDR_CTRL)  en    <= data[CTRL_EN_BIT];
                if (addr == ADDR_PRESC) presc <= data;
            end

            if (load_req)  load_pending <= 1'b1;
            else if (copy) load_pending <= 1'b0;
            if (copy) duty_act <= duty_sh;

            if (en_rise) begin
                presc_cnt <= '0;
                cnt       <= '0;
            end else if (advance) begin
                presc_cnt <= '0;
                presc_act <= presc;
                cnt       <= wrap ? '0 : cnt + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 8'd1;
            end

            for (int ch = 0; ch < NUM_CH; ch++)
                PWMOutputs[ch] <= en && (cnt < duty_act[ch]);
        end
    end

endmodule

// File: tb/tb_spi_pwm_expander.sv
// Directed bench for spi_pwm_expander: SPI register access, PWM duty/period
// measurement, shadow/LOAD timing, frame abort and reset in mid-frame.
module tb_spi_pwm_expander;

    localparam int NUM_CH   = 8;
    localparam int PWM_BITS = 8;

    logic              CLK;
    logic              RST;
    logic              _CS;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NUM_CH-1:0] PWMOutputs;

    int n_cmp = 0;
    int n_bad = 0;

    spi_pwm_expander #(
        .NUM_CH   (NUM_CH),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        ._CS        (_CS),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .PWMOutputs (PWMOutputs)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode 0: MOSI set while SCLK low, MISO captured just before each rise.
    task automatic spi_bits(input logic [15:0] word, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = word[15-i];
            #50;
            if (i >= 8) rx = {rx[6:0], MISO};
            SCLK = 1'b1;
            #50;
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                             output logic [7:0] rx);
        _CS = 1'b0;
        #100;
        spi_bits({b0, b1}, nbits, rx);
        #100;
        _CS = 1'b1;
        #200;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rx;
        spi_frame({1'b1, a}, d, 16, rx);
    endtask

    task automatic spi_read(input logic [6:0] a, output logic [7:0] rx);
        spi_frame({1'b0, a}, 8'h00, 16, rx);
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge CLK);
            hi += int'(PWMOutputs[ch]);
        end
    endtask

    task automatic count_any(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge CLK);
            hi += int'(|PWMOutputs);
        end
    endtask

    task automatic wait_rise(input int ch, input int budget, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = PWMOutputs[ch];
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (!prev && PWMOutputs[ch]) ok = 1'b1;
            prev = PWMOutputs[ch];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        int         hi;
        int         pre;
        bit         ok;
        logic       prev;

        RST  = 1'b1;
        _CS  = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pwm", 32'(PWMOutputs), 0);
        check("rst_miso", 32'(MISO), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_pwm", 32'(PWMOutputs), 0);
        check("post_rst_miso", 32'(MISO), 0);
        #200;

        spi_read(7'h40, rx);  check("rd_ctrl_reset", 32'(rx), 32'h00);
        spi_read(7'h41, rx);  check("rd_presc_reset", 32'(rx), 32'h00);

        // Readback of a duty shadow and of unmapped addresses.
        spi_write(7'h00, 8'hA5);
        spi_read(7'h00, rx);  check("rd_duty0_a5", 32'(rx), 32'hA5);
        spi_write(7'h7F, 8'h5A);
        spi_read(7'h7F, rx);  check("rd_unmapped_7f", 32'(rx), 32'h00);
        spi_read(7'h08, rx);  check("rd_unmapped_08", 32'(rx), 32'h00);

        // Duty 0x40 on ch0, 0x10 on ch1, enable with LOAD.
        spi_write(7'h00, 8'h40);
        spi_write(7'h01, 8'h10);
        spi_write(7'h40, 8'h03);
        check("pwm_low_before_wrap", 32'(PWMOutputs), 0);
        spi_write(7'h41, 8'h00);
        wait_rise(0, 1000, ok);
        check("ch0_first_rise", 32'(ok), 1);
        count_high(0, 510, hi); check("ch0_duty_40", hi, 128);
        count_high(1, 510, hi); check("ch1_duty_10", hi, 32);

        // Shadow change without LOAD leaves the active duty alone.
        spi_write(7'h01, 8'h80);
        count_high(1, 510, hi); check("ch1_no_load", hi, 32);
        spi_read(7'h01, rx);    check("rd_duty1_shadow", 32'(rx), 32'h80);

        // Place the LOAD write well inside a period, then watch for the next wrap.
        wait_rise(0, 400, ok);
        check("ch0_sync_rise", 32'(ok), 1);
        repeat (150) @(negedge CLK);
        spi_write(7'h40, 8'h03);
        pre  = 0;
        ok   = 1'b0;
        prev = PWMOutputs[0];
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge CLK);
            if (!prev && PWMOutputs[0]) ok = 1'b1;
            else pre += int'(PWMOutputs[1]);
            prev = PWMOutputs[0];
        end
        check("load_wrap_seen", 32'(ok), 1);
        check("ch1_before_wrap", pre, 0);
        count_high(1, 255, hi); check("ch1_after_load", hi, 128);
        spi_read(7'h40, rx);    check("rd_ctrl_loaded", 32'(rx), 32'h01);

        // A frame cut short after 12 bits must not write.
        spi_write(7'h02, 8'h11);
        _CS = 1'b0;
        #100;
        spi_bits(16'h8255, 12, rx);
        #100;
        _CS = 1'b1;
        #200;
        spi_read(7'h02, rx);    check("abort_no_write", 32'(rx), 32'h11);
        spi_write(7'h02, 8'h33);
        spi_read(7'h02, rx);    check("after_abort_write", 32'(rx), 32'h33);

        // Duty extremes, then global disable.
        spi_write(7'h02, 8'h00);
        spi_write(7'h03, 8'hFF);
        spi_write(7'h40, 8'h03);
        repeat (600) @(negedge CLK);
        count_high(2, 255, hi); check("duty00_const_low", hi, 0);
        count_high(3, 255, hi); check("dutyff_const_high", hi, 255);
        spi_write(7'h40, 8'h00);
        repeat (5) @(negedge CLK);
        count_any(255, hi);     check("en0_all_low", hi, 0);

        // Reset in the middle of a frame; the rest of that window must be ignored.
        spi_write(7'h40, 8'h03);
        repeat (20) @(negedge CLK);
        check("ch3_active_pre_rst", 32'(PWMOutputs[3]), 1);
        _CS = 1'b0;
        #100;
        spi_bits(16'hC1AB, 4, rx);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_pwm", 32'(PWMOutputs), 0);
        check("midrst_miso", 32'(MISO), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_post_pwm", 32'(PWMOutputs), 0);
        spi_bits(16'hC1AB, 16, rx);
        #100;
        _CS = 1'b1;
        #200;
        spi_read(7'h41, rx);    check("span_frame_dropped", 32'(rx), 32'h00);
        spi_read(7'h00, rx);    check("rst_duty0_clear", 32'(rx), 32'h00);
        spi_read(7'h40, rx);    check("rst_ctrl_clear", 32'(rx), 32'h00);
        check("rst_pwm_idle", 32'(PWMOutputs), 0);
        spi_write(7'h03, 8'h77);
        spi_read(7'h03, rx);    check("fresh_frame_write", 32'(rx), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_pwm_expander.md
SPI_PWM_EXPANDER -- requirements
Module: spi_pwm_expander

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of PWM channels (1..64).
REQ-002 SHALL have parameter PWM_BITS, default 8, duty and counter resolution (2..8).
REQ-003 SHALL have port CLK, input, 1, the single system clock.
REQ-004 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port _CS, input, 1, SPI chip select, active-low, asynchronous to CLK.
REQ-006 SHALL have port SCLK, input, 1, SPI clock (mode 0), asynchronous to CLK, at most CLK/8.
REQ-007 SHALL have port MOSI, input, 1, SPI data in, MSB first.
REQ-008 SHALL have port MISO, output, 1, SPI data out, MSB first.
REQ-009 SHALL have port PWMOutputs, output, NUM_CH, one PWM waveform per channel.

Function
REQ-010 SHALL pass _CS, SCLK and MOSI through 2-FF synchronisers into CLK, then detect SCLK rise and fall edges.
REQ-011 SHALL frame 16 bits per _CS-low window: byte0 = {RW (1 = write), ADDR[6:0]}, byte1 = DATA[7:0].
REQ-012 SHALL sample MOSI on each synchronised SCLK rise while _CS is low.
REQ-013 SHALL decode ADDR after rise 8; on a read it SHALL load the addressed value into the output shift register.
REQ-014 SHALL drive MISO from the shift register MSB, advancing one bit on each synchronised SCLK fall after rise 8.
REQ-015 SHALL hold MISO at 0 when _CS is high or during byte0.
REQ-016 SHALL commit a write on rise 16, one CLK after the edge is detected.
REQ-017 SHALL abort a frame when _CS rises before rise 16: no register change, bit counter cleared.
REQ-018 SHALL ignore extra SCLK edges after rise 16 until _CS goes high.
REQ-019 SHALL map the registers as follows:
- 0x00..NUM_CH-1: DUTY_SH[ch] (shadow), low PWM_BITS bits significant.
- 0x40: CTRL. Bit0 = EN; bit1 = LOAD, write-1-to-request.
- 0x41: PRESC[7:0].
REQ-020 SHALL return 0x00 on a read of an unmapped address and SHALL ignore a write to one.
REQ-021 SHALL read back DUTY_SH for duty addresses, not the active values.
REQ-022 SHALL read CTRL as {6'b0, load_pending, EN}.
REQ-023 SHALL generate a prescale tick once every PRESC+1 CLK cycles, so PRESC = 0 gives a tick every cycle.
REQ-024 SHALL advance the period counter by one on each tick, over 0..2^PWM_BITS-2, wrapping to 0.
- The period is 2^PWM_BITS-1 ticks.
REQ-025 SHALL drive PWMOutputs[ch] = EN AND (cnt < DUTY_ACT[ch]), registered.
- duty 0 gives constant low.
- duty >= 2^PWM_BITS-1 gives constant high.
REQ-026 SHALL copy every DUTY_SH into DUTY_ACT and clear load_pending on the tick where the counter wraps to 0, if load_pending is set.
REQ-027 SHALL set load_pending on a CTRL write with bit1 = 1.
- If this write and a wrap occur in the same CLK, the copy SHALL happen at the next wrap.
REQ-028 SHALL clear the prescaler and counter to 0 when EN goes from 0 to 1.
REQ-029 SHALL take a new PRESC value into effect at the next prescaler rollover.

Reset
REQ-030 SHALL clear on RST high at a CLK edge: all DUTY_SH and DUTY_ACT, CTRL, load_pending, PRESC, counters, SPI bit counter, shift registers and synchronisers.
REQ-031 SHALL hold PWMOutputs = 0 and MISO = 0 during reset and in the first cycle after it.
REQ-032 SHALL discard an SPI frame that spans the reset; SPI SHALL resynchronise only after _CS next goes high.

Structure
REQ-033 SHALL define in a shared package spi_pwm_pkg: the register address constants (CTRL = 0x40, PRESC = 0x41), the CTRL bit indices and the SPI frame length (16).
REQ-034 SHALL contain one sub-module, spi_slave_frame, holding the synchronisers, edge detect, bit counter and shift registers, presenting a one-cycle wr_strobe/addr/data and a rd_addr/rd_data handshake.

Verification
REQ-035 SHALL pass: write 0x40 to DUTY_SH[0], CTRL = 0x03, PRESC = 0 -> after the first wrap, PWMOutputs[0] is high 64 of every 255 CLK.
REQ-036 SHALL pass: read address 0x00 after writing 0xA5 -> MISO returns 0xA5; read 0x7F -> 0x00.
REQ-037 SHALL pass: change DUTY_SH[1] from 0x10 to 0x80 without LOAD -> output unchanged; after a LOAD write, it changes exactly at the next wrap.
REQ-038 SHALL pass: raise _CS after 12 bits of a write to 0x02 -> DUTY_SH[2] unchanged; the next full frame writes correctly.
REQ-039 SHALL pass: duty 0x00 and 0xFF with EN = 1 -> constant low and constant high; EN = 0 -> all outputs low.
REQ-040 SHALL pass: assert RST mid-frame with outputs active -> all registers 0, outputs 0; a fresh frame after a _CS high then works.
